pkt_fifo: RTL and testbench

Parametrised synchronous FIFO for byte-stream packet buffering in the UDP/IP datapath. It is the successor to the fixed 8-bit FIFO and adds configurable width and depth, occupancy and packet counters, and an almost-full flag. It also has a packet mode: a packet becomes readable only after its last word is written, and a packet that overflows or is aborted is discarded whole. It sits between the byte-serial receive path and the header/checksum logic.

---
 rtl/pkt_fifo.sv | 170 +++++++++++++++++
 tb/tb_pkt_fifo.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_fifo.sv
// pkt_fifo: parametrised synchronous FIFO with optional packet commit/drop.
// Storage holds {last, data}. wr_ptr advances on every accepted write, cm_ptr
// marks the end of the last committed packet, rd_ptr the next word to read.
// Readers only see words between rd_ptr and cm_ptr.
module pkt_fifo #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned ADDR_W    = 11,
  parameter int unsigned AFULL_LVL = 2040,
  parameter int unsigned PKT_MODE  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  din,
  input  logic              wr_en,
  input  logic              wr_last,
  input  logic              wr_abort,
  input  logic              rd_en,
  output logic [WIDTH-1:0]  dout,
  output logic              dout_last,
  output logic              empty,
  output logic              full,
  output logic              almost_full,
  output logic [ADDR_W:0]   count,
  output logic [ADDR_W:0]   pkt_count,
  output logic              overflow,
  output logic              underflow
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned PW    = ADDR_W + 1;
  localparam int unsigned MW    = WIDTH + 1;

  logic [MW-1:0]    mem_q [DEPTH];

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    cm_ptr_q, cm_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    pkt_cnt_q, pkt_cnt_d;
  logic             bad_q, bad_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dout_last_q, dout_last_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;

  logic [PW-1:0]    used;
  logic [PW-1:0]    cnt;
  logic             full_s;
  logic             empty_s;
  logic [MW-1:0]    rd_word;
  logic             wr_acc;
  logic             commit;
  logic             rd_last;

  // Occupancy and flags derived from the registered pointers
  assign used    = wr_ptr_q - rd_ptr_q;
  assign cnt     = cm_ptr_q - rd_ptr_q;
  assign full_s  = (used == PW'(DEPTH));
  assign empty_s = (cnt == '0);
  assign rd_word = mem_q[rd_ptr_q[ADDR_W-1:0]];

  assign dout        = dout_q;
  assign dout_last   = dout_last_q;
  assign empty       = empty_s;
  assign full        = full_s;
  assign almost_full = (32'(used) >= AFULL_LVL);
  assign count       = cnt;
  assign pkt_count   = pkt_cnt_q;
  assign overflow    = ovf_q;
  assign underflow   = udf_q;

  // Next-state: read side, write/commit/drop side, packet counter
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    cm_ptr_d    = cm_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    pkt_cnt_d   = pkt_cnt_q;
    bad_d       = bad_q;
    dout_d      = dout_q;
    dout_last_d = dout_last_q;
    ovf_d       = 1'b0;
    udf_d       = 1'b0;
    wr_acc      = 1'b0;
    commit      = 1'b0;
    rd_last     = 1'b0;

    if (rd_en) begin
      if (empty_s) begin
        udf_d = 1'b1;
      end else begin
        {dout_last_d, dout_d} = rd_word;
        rd_ptr_d              = rd_ptr_q + PW'(1);
        rd_last               = rd_word[WIDTH];
      end
    end

    if (PKT_MODE == 0) begin
      if (wr_en) begin
        if (full_s) begin
          ovf_d = 1'b1;
        end else begin
          wr_acc   = 1'b1;
          wr_ptr_d = wr_ptr_q + PW'(1);
          cm_ptr_d = wr_ptr_q + PW'(1);
          commit   = wr_last;
        end
      end
    end else if (wr_abort) begin
      // Abort rewinds the open packet; a write on the same edge is dropped
      wr_ptr_d = cm_ptr_q;
      bad_d    = 1'b0;
    end else if (wr_en) begin
      if (bad_q || full_s) begin
        // Packet no longer fits: swallow words until its last, then drop it
        if (wr_last) begin
          wr_ptr_d = cm_ptr_q;
          bad_d    = 1'b0;
          ovf_d    = 1'b1;
        end else begin
          bad_d = 1'b1;
        end
      end else begin
        wr_acc   = 1'b1;
        wr_ptr_d = wr_ptr_q + PW'(1);
        if (wr_last) begin
          cm_ptr_d = wr_ptr_q + PW'(1);
          commit   = 1'b1;
        end
      end
    end

    case ({commit, rd_last})
      2'b10:   pkt_cnt_d = pkt_cnt_q + PW'(1);
      2'b01:   pkt_cnt_d = pkt_cnt_q - PW'(1);
      default: pkt_cnt_d = pkt_cnt_q;
    endcase
  end

  // Pointer, flag and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      cm_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      pkt_cnt_q   <= '0;
      bad_q       <= 1'b0;
      dout_q      <= '0;
      dout_last_q <= 1'b0;
      ovf_q       <= 1'b0;
      udf_q       <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      cm_ptr_q    <= cm_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      pkt_cnt_q   <= pkt_cnt_d;
      bad_q       <= bad_d;
      dout_q      <= dout_d;
      dout_last_q <= dout_last_d;
      ovf_q       <= ovf_d;
      udf_q       <= udf_d;
    end
  end

  // Storage array write port; contents need no reset
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem_q[wr_ptr_q[ADDR_W-1:0]] <= {wr_last, din};
    end
  end

endmodule

// File: tb/tb_pkt_fifo.sv
// tb_pkt_fifo: drives three pkt_fifo configurations with shared stimulus
// (2048-deep packet mode, 8-deep packet mode, 8-deep plain mode) and checks
// them against a queue-based reference model through a read scoreboard.
module tb_pkt_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] din;
  logic       wr_en, wr_last, wr_abort, rd_en;

  logic [2:0][7:0]  dout_a;
  logic [2:0]       last_a, empty_a, full_a, afull_a, ovf_a, udf_a;
  logic [2:0][11:0] cnt_a, pcnt_a;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned AW = (g == 0) ? 11 : 3;
    localparam int unsigned PM = (g == 2) ? 0 : 1;
    localparam int unsigned AF = (g == 0) ? 2040 : 6;
    logic [7:0] dout;
    logic       dout_last, empty, full, almost_full, overflow, underflow;
    logic [AW:0] count, pkt_count;

    pkt_fifo #(.WIDTH(8), .ADDR_W(AW), .AFULL_LVL(AF), .PKT_MODE(PM)) u_dut (
      .clk(clk), .rst_n(rst_n), .din(din), .wr_en(wr_en), .wr_last(wr_last),
      .wr_abort(wr_abort), .rd_en(rd_en), .dout(dout), .dout_last(dout_last),
      .empty(empty), .full(full), .almost_full(almost_full), .count(count),
      .pkt_count(pkt_count), .overflow(overflow), .underflow(underflow)
    );

    assign dout_a[g]  = dout;
    assign last_a[g]  = dout_last;
    assign empty_a[g] = empty;
    assign full_a[g]  = full;
    assign afull_a[g] = almost_full;
    assign ovf_a[g]   = overflow;
    assign udf_a[g]   = underflow;
    assign cnt_a[g]   = 12'(count);
    assign pcnt_a[g]  = 12'(pkt_count);
  end

  // Reference model: committed words, open packet words, expected reads
  int cq  [3][$];
  int pq  [3][$];
  int sbq [3][$];
  bit bad_m [3];
  bit ovf_m [3];
  bit udf_m [3];
  int hold_m [3];
  logic [2:0] fire;

  function automatic int depth_of(input int i);
    return (i == 0) ? 2048 : 8;
  endfunction

  function automatic int afl_of(input int i);
    return (i == 0) ? 2040 : 6;
  endfunction

  function automatic int used_m(input int i);
    return cq[i].size() + pq[i].size();
  endfunction

  function automatic int pkts_m(input int i);
    int n = 0;
    for (int k = 0; k < cq[i].size(); k++) if (cq[i][k] >= 256) n++;
    return n;
  endfunction

  function automatic void chk(input string name, input int inst, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s inst%0d: got %0d expected %0d at t=%0t", name, inst, act, exp, $time);
    end
  endfunction

  function automatic void model_reset(input int i);
    cq[i].delete();
    pq[i].delete();
    sbq[i].delete();
    bad_m[i]  = 1'b0;
    ovf_m[i]  = 1'b0;
    udf_m[i]  = 1'b0;
    hold_m[i] = 0;
  endfunction

  // One clock edge of behaviour, using pre-edge model state
  function automatic void model_step(input int i);
    int w;
    bit full_m, empty_m;
    w       = (wr_last ? 256 : 0) + int'(din);
    full_m  = (used_m(i) == depth_of(i));
    empty_m = (cq[i].size() == 0);
    ovf_m[i] = 1'b0;
    udf_m[i] = 1'b0;
    if (rd_en) begin
      if (empty_m) udf_m[i] = 1'b1;
      else sbq[i].push_back(cq[i].pop_front());
    end
    if (i == 2) begin
      if (wr_en) begin
        if (full_m) ovf_m[i] = 1'b1;
        else cq[i].push_back(w);
      end
    end else if (wr_abort) begin
      pq[i].delete();
      bad_m[i] = 1'b0;
    end else if (wr_en) begin
      if (bad_m[i] || full_m) begin
        if (wr_last) begin
          pq[i].delete();
          bad_m[i] = 1'b0;
          ovf_m[i] = 1'b1;
        end else begin
          bad_m[i] = 1'b1;
        end
      end else begin
        pq[i].push_back(w);
        if (wr_last) while (pq[i].size() > 0) cq[i].push_back(pq[i].pop_front());
      end
    end
  endfunction

  // Monitor: note which instances performed a read on this edge
  always @(posedge clk) fire <= (rst_n && rd_en) ? ~empty_a : 3'b000;

  // Monitor: pop scoreboard on reads, compare data and status every cycle
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (fire[i]) begin
        chk("read_expected", i, int'(sbq[i].size() > 0), 1);
        if (sbq[i].size() > 0) hold_m[i] = sbq[i].pop_front();
      end
      chk("dout", i, int'({last_a[i], dout_a[i]}), hold_m[i]);
      chk("empty", i, int'(empty_a[i]), int'(cq[i].size() == 0));
      chk("full", i, int'(full_a[i]), int'(used_m(i) == depth_of(i)));
      chk("almost_full", i, int'(afull_a[i]), int'(used_m(i) >= afl_of(i)));
      chk("count", i, int'(cnt_a[i]), cq[i].size());
      chk("pkt_count", i, int'(pcnt_a[i]), pkts_m(i));
      chk("overflow", i, int'(ovf_a[i]), int'(ovf_m[i]));
      chk("underflow", i, int'(udf_a[i]), int'(udf_m[i]));
    end
  end

  // Apply one cycle of inputs; entered and left at a falling edge
  task automatic cyc(input logic we, input logic wl, input logic ab, input logic re,
                     input logic [7:0] d);
    wr_en = we; wr_last = wl; wr_abort = ab; rd_en = re; din = d;
    @(posedge clk);
    if (rst_n) for (int i = 0; i < 3; i++) model_step(i);
    @(negedge clk);
  endtask

  task automatic drain(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
  endtask

  // Reset asserted between clock edges; outputs must clear immediately
  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    wr_en = 1'b0; wr_last = 1'b0; wr_abort = 1'b0; rd_en = 1'b0;
    for (int i = 0; i < 3; i++) model_reset(i);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("arst_empty", i, int'(empty_a[i]), 1);
      chk("arst_full", i, int'(full_a[i]), 0);
      chk("arst_count", i, int'(cnt_a[i]), 0);
      chk("arst_pkt_count", i, int'(pcnt_a[i]), 0);
      chk("arst_dout", i, int'({last_a[i], dout_a[i]}), 0);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [7:0] pkt37 [37];
  int wp [6] = '{80, 20, 50, 90, 10, 50};
  int rp [6] = '{20, 80, 50, 40, 90, 50};

  initial begin
    rst_n = 1'b0;
    din = 8'h00; wr_en = 1'b0; wr_last = 1'b0; wr_abort = 1'b0; rd_en = 1'b0;
    for (int i = 0; i < 3; i++) model_reset(i);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Idle after reset, then a read while empty
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      chk("rst_empty", i, int'(empty_a[i]), 1);
      chk("rst_almost_full", i, int'(afull_a[i]), 0);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 3; i++) begin
      chk("udf_pulse", i, int'(udf_a[i]), 1);
      chk("udf_dout", i, int'(dout_a[i]), 0);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("udf_single", 0, int'(udf_a[0]), 0);

    // 37-byte UDP packet into the deep packet-mode instance
    pkt37[0] = 8'h45; pkt37[1] = 8'h00; pkt37[2] = 8'h00; pkt37[3] = 8'h25;
    for (int k = 4; k < 36; k++) pkt37[k] = 8'(k * 13 + 1);
    pkt37[36] = 8'h21;
    for (int k = 0; k < 37; k++) begin
      cyc(1'b1, k == 36, 1'b0, 1'b0, pkt37[k]);
      chk("pkt37_empty", 0, int'(empty_a[0]), (k == 36) ? 0 : 1);
    end
    chk("pkt37_count", 0, int'(cnt_a[0]), 37);
    chk("pkt37_pkt_count", 0, int'(pcnt_a[0]), 1);
    for (int k = 0; k < 37; k++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
      chk("pkt37_data", 0, int'(dout_a[0]), int'(pkt37[k]));
      chk("pkt37_last", 0, int'(last_a[0]), (k == 36) ? 1 : 0);
    end
    chk("pkt37_drained", 0, int'(empty_a[0]), 1);
    chk("pkt37_pkt_zero", 0, int'(pcnt_a[0]), 0);
    drain(12);

    // 10-byte packet into 8-deep packet FIFO: dropped whole, then 3-byte packet
    for (int k = 0; k < 10; k++) begin
      cyc(1'b1, k == 9, 1'b0, 1'b0, 8'(8'h60 + k));
      if (k == 7) chk("ovr_full", 1, int'(full_a[1]), 1);
    end
    chk("ovr_pulse", 1, int'(ovf_a[1]), 1);
    chk("ovr_count", 1, int'(cnt_a[1]), 0);
    chk("ovr_full_clr", 1, int'(full_a[1]), 0);
    for (int k = 0; k < 3; k++) cyc(1'b1, k == 2, 1'b0, 1'b0, 8'(8'hA0 + k));
    chk("ovr_pulse_once", 1, int'(ovf_a[1]), 0);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
      chk("after_ovr_data", 1, int'(dout_a[1]), 8'hA0 + k);
    end
    drain(12);

    // Committed packet A, partial packet B, abort
    for (int k = 0; k < 4; k++) cyc(1'b1, k == 3, 1'b0, 1'b0, 8'(8'hB0 + k));
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'hC0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'hC1);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 8'hC2);
    for (int i = 0; i < 2; i++) begin
      chk("abort_count", i, int'(cnt_a[i]), 4);
      chk("abort_pkt_count", i, int'(pcnt_a[i]), 1);
    end
    for (int k = 0; k < 4; k++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
      chk("abort_data", 0, int'(dout_a[0]), 8'hB0 + k);
    end
    chk("abort_empty", 0, int'(empty_a[0]), 1);
    drain(8);

    // Plain mode: fill to 8, overflow, read+write at full, wrap
    for (int k = 1; k <= 8; k++) cyc(1'b1, k == 8, 1'b0, 1'b0, 8'(k));
    chk("raw_full", 2, int'(full_a[2]), 1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'd9);
    chk("raw_ovf", 2, int'(ovf_a[2]), 1);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 8'd10);
    chk("raw_rw_data", 2, int'(dout_a[2]), 1);
    chk("raw_rw_count", 2, int'(cnt_a[2]), 7);
    drain(10);
    for (int r = 0; r < 3; r++) begin
      for (int j = 0; j < 8; j++) cyc(1'b1, j == 7, 1'b0, 1'b0, 8'(16 * r + j + 8'h30));
      for (int j = 0; j < 8; j++) begin
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        chk("raw_wrap_data", 2, int'(dout_a[2]), 16 * r + j + 8'h30);
      end
    end
    drain(4);

    // Reset in the middle of a packet with 5 committed words
    for (int k = 0; k < 5; k++) cyc(1'b1, k == 4, 1'b0, 1'b0, 8'(8'hD0 + k));
    for (int k = 0; k < 3; k++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'(8'hE0 + k));
    chk("pre_rst_count", 0, int'(cnt_a[0]), 5);
    async_reset();
    for (int k = 0; k < 4; k++) cyc(1'b1, k == 3, 1'b0, 1'b0, 8'(8'hF0 + k));
    for (int k = 0; k < 4; k++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
      chk("post_rst_data", 0, int'(dout_a[0]), 8'hF0 + k);
    end
    drain(4);

    // Randomised traffic in phases of differing read/write pressure
    for (int p = 0; p < 6; p++) begin
      for (int c = 0; c < 400; c++) begin
        cyc($urandom_range(99, 0) < wp[p], $urandom_range(7, 0) == 0,
            $urandom_range(63, 0) == 0, $urandom_range(99, 0) < rp[p],
            8'($urandom_range(255, 0)));
      end
    end
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    for (int c = 0; c < 3000; c++) begin
      if (cq[0].size() == 0 && cq[1].size() == 0 && cq[2].size() == 0) break;
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      chk("final_empty", i, int'(empty_a[i]), 1);
      chk("scoreboard_drained", i, sbq[i].size(), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
